data_mem_arbiter: RTL

- Shares the single-port data RAM between two requesters: requester 0 is the MIPS core load/store path; requester 1 is the external loader/debug port.
- Uses round-robin arbitration and a 3-state transaction FSM.
- Translates the byte address from the MIPS data segment into a RAM word index, and flags out-of-window or misaligned accesses.
- Sits between the core/loader and the data RAM. The core's stall logic uses cpu_ack.

---
 rtl/data_mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the MIPS core
// (requester 0) and the external loader/debug port (requester 1).
// Round-robin arbitration, a three-state transaction FSM (IDLE -> CMD -> RESP),
// and translation of MIPS data-segment byte addresses into RAM word indices.
//
// Handshake (both requesters): a requester raises req together with a stable
// command (we/addr/wdata) and holds all of them until it samples ack=1. On the
// edge that ends the ack cycle it either drops req or presents its next command.
// A req still high in the following IDLE cycle is a new transaction. ack is a
// one-cycle pulse, and rdata/err are meaningful only while ack=1.
module data_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          AW           = $clog2(MEMORY_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    // core load/store path
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    // external loader/debug path
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [31:0]   ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic          ext_ack,
    output logic [31:0]   ext_rdata,
    output logic          ext_err,
    // data RAM port
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [31:0]   mem_rdata,
    // status
    output logic          busy,
    output logic [1:0]    dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } stateT;

    // One byte past the last RAM word; the window is [BASE_ADDR, LIMIT_ADDR).
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * MEMORY_DEPTH);
    localparam logic [31:0] LIMIT_ADDR   = BASE_ADDR + WINDOW_BYTES;

    stateT       state;
    logic        lastWinExt;   // 1 = ext won the last grant, so cpu is favoured next
    logic        grantExt;     // winner of the transaction in flight
    logic        errLatched;   // in-flight access was out of window or misaligned

    logic        pickExt;
    logic        selWe;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selOk;
    logic [AW-1:0] selIdx;
    logic [31:0] respData;

    // Arbitration and address decode of the candidate command seen in IDLE
    always_comb begin
        pickExt  = 1'b0;
        if (ext_req && (!cpu_req || !lastWinExt)) begin
            pickExt = 1'b1;
        end
        selWe    = pickExt ? ext_we    : cpu_we;
        selAddr  = pickExt ? ext_addr  : cpu_addr;
        selWdata = pickExt ? ext_wdata : cpu_wdata;
        selOk    = (selAddr[1:0] == 2'b00) &&
                   (selAddr >= BASE_ADDR) &&
                   (selAddr < LIMIT_ADDR);
        selIdx   = AW'((selAddr - BASE_ADDR) >> 2);
    end

    // Read data to hand back; mem_re is only ever high for a valid read
    always_comb begin
        respData = 32'h0;
        if (mem_re) begin
            respData = mem_rdata;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lastWinExt <= 1'b1;
            grantExt   <= 1'b0;
            errLatched <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= 32'h0;
            cpu_err    <= 1'b0;
            ext_ack    <= 1'b0;
            ext_rdata  <= 32'h0;
            ext_err    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || ext_req) begin
                        grantExt   <= pickExt;
                        lastWinExt <= pickExt;
                        errLatched <= !selOk;
                        mem_addr   <= selOk ? selIdx : '0;
                        mem_wdata  <= selWdata;
                        mem_we     <= selOk && selWe;
                        mem_re     <= selOk && !selWe;
                        busy       <= 1'b1;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    // strobes last exactly this one cycle; capture the read data now
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    if (grantExt) begin
                        ext_ack   <= 1'b1;
                        ext_err   <= errLatched;
                        ext_rdata <= respData;
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_err   <= errLatched;
                        cpu_rdata <= respData;
                    end
                    state <= RESP;
                end
                RESP: begin
                    // no arbitration here; a waiting request is seen in the next IDLE
                    cpu_ack   <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= 32'h0;
                    ext_ack   <= 1'b0;
                    ext_err   <= 1'b0;
                    ext_rdata <= 32'h0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign dbgState = state;

    // Memory strobes belong to CMD only and never overlap
    always @(posedge clk) begin
        if (!reset) begin
            assert (!mem_we || state == CMD) else $error("mem_we outside CMD");
            assert (!(mem_we && mem_re)) else $error("mem_we and mem_re together");
            assert (!(cpu_ack && ext_ack)) else $error("both acks high");
        end
    end

endmodule
